// File: rtl/lif_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

    localparam int unsigned STATE_W           = 8;
    localparam int unsigned DEFAULT_THRESHOLD = 200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } lif_state_t;

endpackage

// File: rtl/lif_spike_fifo.sv
// Small circular FIFO holding neuron indices of pending spike events.
module lif_spike_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Leaky integrate-and-fire scheduler: one sweep per tick updates every neuron in turn
// and queues spike events for a downstream consumer.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int unsigned N_NEURONS   = 4,
    parameter int unsigned THRESHOLD   = DEFAULT_THRESHOLD,
    parameter int unsigned SPIKE_DEPTH = 2,
    localparam int unsigned IDX_W      = $clog2(N_NEURONS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cur_valid,
    output logic               cur_ready,
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic [STATE_W-1:0] cur_data,
    input  logic               tick,
    output logic               busy,
    output logic               spike_valid,
    input  logic               spike_ready,
    output logic [IDX_W-1:0]   spike_idx,
    output logic               tick_overrun
);

    lif_state_t         state_q;
    lif_state_t         state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [STATE_W-1:0] mem [N_NEURONS];
    logic [STATE_W-1:0] cur [N_NEURONS];

    logic [STATE_W-1:0] v_c;
    logic               fire_c;
    logic               upd_c;
    logic               push_c;
    logic               pop_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic               cur_wr_c;

    assign cur_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign spike_valid = !fifo_empty;
    assign pop_c       = spike_valid && spike_ready;
    assign cur_wr_c    = cur_valid && cur_ready;

    // Integrate with a doubling leak term; wraps modulo 2^STATE_W.
    assign v_c    = STATE_W'(cur[ptr_q] + (mem[ptr_q] << 1));
    assign fire_c = (v_c >= STATE_W'(THRESHOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        upd_c   = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                // Hold the neuron untouched until its spike can be queued.
                if (fire_c && fifo_full && !pop_c) begin
                    state_d = ST_STALL;
                end else begin
                    upd_c  = 1'b1;
                    push_c = fire_c;
                    if (ptr_q == IDX_W'(N_NEURONS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            ST_STALL: begin
                if (!fifo_full || pop_c) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                mem[i] <= '0;
                cur[i] <= '0;
            end
        end else begin
            if (cur_wr_c) begin
                cur[cur_idx] <= cur_data;
            end
            if (upd_c) begin
                mem[ptr_q] <= fire_c ? '0 : v_c;
                cur[ptr_q] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_overrun <= 1'b0;
        end else if (tick && busy) begin
            tick_overrun <= 1'b1;
        end
    end

    lif_spike_fifo #(
        .DEPTH (SPIKE_DEPTH),
        .WIDTH (IDX_W)
    ) u_spike_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (ptr_q),
        .pop       (pop_c),
        .pop_data  (spike_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of time-multiplexed neurons (power of two, 2..16).
REQ-002 SHALL have parameter THRESHOLD, default 200, 8-bit spike threshold.
REQ-003 SHALL have parameter SPIKE_DEPTH, default 2, spike FIFO entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cur_valid  in  1  current-write request.
REQ-007 cur_ready  out  1  current-write accept.
REQ-008 cur_idx  in  IDX_W=log2(N_NEURONS)  target neuron.
REQ-009 cur_data  in  8  input current.
REQ-010 tick  in  1  single-cycle pulse requesting one update sweep.
REQ-011 busy  out  1  sweep in progress.
REQ-012 spike_valid  out  1  spike event available.
REQ-013 spike_ready  in  1  consumer accepts spike event.
REQ-014 spike_idx  out  IDX_W  neuron that spiked.
REQ-015 tick_overrun  out  1  sticky: tick arrived while busy.

Function
REQ-016 SHALL hold one 8-bit membrane register and one 8-bit pending-current register per neuron.
REQ-017 cur_ready SHALL equal (fsm==IDLE); a write is accepted when cur_valid&&cur_ready; it overwrites the pending current of cur_idx (last write wins).
REQ-018 FSM states: IDLE, SWEEP, STALL, DONE.
REQ-019 IDLE->SWEEP on tick; neuron pointer set to 0. A write and tick in the same IDLE cycle SHALL both be taken; the written current SHALL be used in that sweep.
REQ-020 In SWEEP, one neuron i per cycle: v = (cur[i] + (mem[i] << 1)) truncated to 8 bits.
REQ-021 If v >= THRESHOLD: push i into spike FIFO, mem[i] <= 0; else mem[i] <= v; cur[i] <= 0 in both cases.
REQ-022 If a spike push is required but the FIFO is full and not popping that cycle, SHALL enter STALL without updating neuron i; STALL->SWEEP re-evaluates i once space exists.
REQ-023 After neuron N_NEURONS-1 is updated SHALL go SWEEP->DONE->IDLE (DONE one cycle).
REQ-024 busy SHALL be high in SWEEP, STALL, DONE.
REQ-025 Latency: tick in cycle t -> neuron i updated at the edge ending cycle t+1+i (no stalls); its spike visible on spike_valid in cycle t+2+i; busy low from cycle t+N_NEURONS+2.
REQ-026 tick while busy SHALL be ignored and set tick_overrun until reset.
REQ-027 spike_valid = FIFO non-empty; spike_idx = head; pop on spike_valid&&spike_ready; push and pop in the same cycle allowed when full.
REQ-028 FIFO order SHALL be ascending neuron index within a sweep, sweeps in order.

Reset
REQ-029 On reset: fsm=IDLE, pointer=0, all mem and cur = 0, FIFO empty, tick_overrun=0; outputs: cur_ready=1, busy=0, spike_valid=0, spike_idx=0.
REQ-030 Reset mid-sweep SHALL abort the sweep with no partial state retained.

Structure
REQ-031 Shared package lif_pkg SHALL hold STATE_W=8, default THRESHOLD, and the FSM state enum.
REQ-032 Spike queue SHALL be a sub-module lif_spike_fifo (parameter depth/width, push/pop/full/empty).

Verification
REQ-033 cur[0]=100, tick -> mem[0]=100, no spike; then cur[0]=10, tick -> v=210, spike_idx=0, mem[0]=0.
REQ-034 cur[1]=150, tick; then tick with no write -> v=300 mod 256=44, mem[1]=44, no spike.
REQ-035 spike_ready=0, cur[0..3]=250, tick -> two spikes (0,1) queued, STALL at neuron 2, busy held; raise spike_ready -> events 0,1,2,3 in order, sweep completes.
REQ-036 tick again 2 cycles after first tick -> ignored, tick_overrun=1, only one sweep performed.
REQ-037 Assert reset during SWEEP at neuron 2 -> all mem=0, spike_valid=0, busy=0, cur_ready=1 immediately (asynchronous).
REQ-038 Same-cycle cur write (idx 3, 220) and tick in IDLE -> spike_idx=3 emitted in cycle t+5.
